// File: rtl/fdt16_pkg.sv
// Shared definitions for the fdt16 core: opcodes, control FSM states, ALU ops and PC sources.
// Used by the control sequencer, the ALU and the datapath.
package fdt16_pkg;

    localparam int unsigned OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_NOP  = 6'h00;
    localparam logic [OPC_W-1:0] OP_HLT  = 6'h01;
    localparam logic [OPC_W-1:0] OP_LDI  = 6'h02;
    localparam logic [OPC_W-1:0] OP_LDA  = 6'h03;
    localparam logic [OPC_W-1:0] OP_STA  = 6'h04;
    localparam logic [OPC_W-1:0] OP_ADD  = 6'h05;
    localparam logic [OPC_W-1:0] OP_SUB  = 6'h06;
    localparam logic [OPC_W-1:0] OP_ANDI = 6'h07;
    localparam logic [OPC_W-1:0] OP_ORI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'h09;
    localparam logic [OPC_W-1:0] OP_BRZ  = 6'h0A;
    localparam logic [OPC_W-1:0] OP_JMP  = 6'h0B;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_PASS_B = 3'd4;

    localparam logic [1:0] PC_SRC_INC = 2'd0;
    localparam logic [1:0] PC_SRC_REL = 2'd1;
    localparam logic [1:0] PC_SRC_IMM = 2'd2;

    function automatic logic opc_is_legal(input logic [OPC_W-1:0] op);
        return op <= OP_JMP;
    endfunction

    // Only the logical-immediate ops treat ir[8:0] as an unsigned mask.
    function automatic logic opc_zext(input logic [OPC_W-1:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic opc_uses_mem(input logic [OPC_W-1:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/fdt16_mem_timer.sv
// Wait-cycle counter for the memory handshake; flags expiry on the last allowed waiting cycle.
module fdt16_mem_timer
    import fdt16_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the waits already spent, so this cycle is wait number count_q+1.
    assign expired_o = en_i && (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/fdt16_ctrl_fsm.sv
// Multicycle control sequencer for the fdt16 core: fetch/decode/execute/memory/writeback
// with a bounded memory handshake and sticky illegal-opcode / bus-error halts.
module fdt16_ctrl_fsm
    import fdt16_pkg::*;
#(
    parameter int unsigned OPC_W   = 6,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_op,
    output logic        alu_b_sel,
    output logic        ext_zero,
    output logic        acc_we,
    output logic        acc_src,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [OPC_W-1:0] opcode;
    logic             in_wait;
    logic             expired;
    logic             unused_ir_bits;

    assign opcode         = ir[15 -: OPC_W];
    assign unused_ir_bits = ^ir[15-OPC_W:0];
    assign in_wait        = (state_q == ST_FETCH) || (state_q == ST_MEM);

    fdt16_mem_timer #(.TIMEOUT(TIMEOUT)) u_mem_timer (
        .clk       (clk),
        .rst       (rst),
        .en_i      (in_wait && !mem_ready),
        .clr_i     (!in_wait || mem_ready),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        unique case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_NOP) begin
                    state_d = ST_FETCH;
                end else if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end else if (!opc_is_legal(opcode)) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:  state_d = opc_uses_mem(opcode) ? ST_MEM : ST_FETCH;
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (opcode == OP_STA) ? ST_FETCH : ST_WB;
                end else if (expired) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_WB:    state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_INC;
        alu_op    = ALU_ADD;
        alu_b_sel = 1'b0;
        ext_zero  = 1'b0;
        acc_we    = 1'b0;
        acc_src   = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        bus_err   = 1'b0;
        if (!rst) begin
            illegal  = illegal_q;
            bus_err  = bus_err_q;
            halted   = (state_q == ST_HALT);
            ext_zero = (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) && opc_zext(opcode);
            unique case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                ST_EXEC: begin
                    unique case (opcode)
                        OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: begin
                            alu_b_sel = 1'b1;
                            acc_we    = 1'b1;
                            alu_op    = (opcode == OP_LDI)  ? ALU_PASS_B :
                                        (opcode == OP_ANDI) ? ALU_AND    :
                                        (opcode == OP_ORI)  ? ALU_OR     : ALU_ADD;
                        end
                        OP_BRZ: begin
                            pc_we  = zero_flag;
                            pc_src = PC_SRC_REL;
                        end
                        OP_JMP: begin
                            pc_we  = 1'b1;
                            pc_src = PC_SRC_REL;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (opcode == OP_STA);
                end
                ST_WB: begin
                    acc_we  = 1'b1;
                    acc_src = (opcode == OP_LDA);
                    alu_op  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                end
                default: ;
            endcase
        end
    end

endmodule
